// File: rtl/elevator_scan_ctrl_if.sv
// rtl/elevator_scan_ctrl_if.sv - call/button inputs and car status outputs of the elevator controller
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
);
  logic [NUM_FLOORS-1:0] car_call;
  logic [NUM_FLOORS-1:0] hall_up;
  logic [NUM_FLOORS-1:0] hall_dn;
  logic                  open_door;
  logic                  close_door;
  logic                  over_weight;
  logic [FLOOR_W-1:0]    current_floor;
  logic [1:0]            direction;
  logic                  door_state;
  logic                  over_weight_alert;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output car_call, hall_up, hall_dn, open_door, close_door, over_weight,
    input  current_floor, direction, door_state, over_weight_alert, pending
  );

  modport slave (
    input  car_call, hall_up, hall_dn, open_door, close_door, over_weight,
    output current_floor, direction, door_state, over_weight_alert, pending
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor SCAN elevator controller with door dwell and overweight hold
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  elevator_scan_ctrl_if.slave bus
);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [1:0] DIR_IDLE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state, state_n;
  logic [FLOOR_W-1:0]    floor, floor_n, nf, door_f;
  logic [1:0]            dir, dir_n;
  logic                  door, door_n, alert, last_up, last_up_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [DW-1:0]         dcnt, dcnt_n;
  logic [NUM_FLOORS-1:0] pc, pu, pd, pc_n, pu_n, pd_n, pend;
  logic [NUM_FLOORS-1:0] car_q, up_q, dn_q, set_mask, clr_oh;
  logic                  enter_door, ahead, behind, ahead_nf, ahead_f, here_new;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && v[i]) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && v[i]) any_below = 1'b1;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    for (int i = 0; i < NUM_FLOORS; i++) onehot[i] = (i == int'(f));
  endfunction

  assign pend = pc | pu | pd;

  always_comb begin
    state_n    = state;
    floor_n    = floor;
    dir_n      = dir;
    door_n     = door;
    last_up_n  = last_up;
    tcnt_n     = tcnt;
    dcnt_n     = dcnt;
    enter_door = 1'b0;
    door_f     = floor;
    nf         = floor;
    set_mask   = '1;
    here_new   = 1'b0;
    ahead_nf   = 1'b0;
    ahead      = last_up ? any_above(pend, floor) : any_below(pend, floor);
    behind     = last_up ? any_below(pend, floor) : any_above(pend, floor);
    case (state)
      IDLE: begin
        dir_n = DIR_IDLE;
        // An opposite hall call here waits until nothing is left ahead, otherwise the door would reopen forever.
        if (bus.open_door || pc[floor] || (last_up ? pu[floor] : pd[floor]) ||
            ((last_up ? pd[floor] : pu[floor]) && !ahead)) begin
          state_n    = DOOR;
          enter_door = 1'b1;
        end else if (ahead) begin
          state_n = MOVE;
          tcnt_n  = '0;
          dir_n   = last_up ? DIR_UP : DIR_DN;
        end else if (behind) begin
          state_n   = MOVE;
          tcnt_n    = '0;
          last_up_n = !last_up;
          dir_n     = last_up ? DIR_DN : DIR_UP;
        end
      end
      MOVE: begin
        if (tcnt == T_LAST) begin
          tcnt_n = '0;
          if (last_up) nf = (floor == TOP) ? floor : floor + 1'b1;
          else         nf = (floor == '0)  ? floor : floor - 1'b1;
          floor_n  = nf;
          ahead_nf = last_up ? any_above(pend, nf) : any_below(pend, nf);
          if (pc[nf] || (last_up ? pu[nf] : pd[nf]) || ((last_up ? pd[nf] : pu[nf]) && !ahead_nf)) begin
            state_n    = DOOR;
            enter_door = 1'b1;
            door_f     = nf;
            dir_n      = DIR_IDLE;
          end else if (!ahead_nf) begin
            state_n = IDLE;
            dir_n   = DIR_IDLE;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DOOR: begin
        here_new = car_q[floor] | up_q[floor] | dn_q[floor];
        set_mask = ~onehot(floor);
        if (bus.open_door || here_new) begin
          dcnt_n = D_LOAD;
        end else if (!bus.over_weight) begin
          if (bus.close_door || dcnt <= DW'(1)) begin
            state_n = IDLE;
            door_n  = 1'b0;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (enter_door) begin
      door_n = 1'b1;
      dcnt_n = D_LOAD;
    end
    ahead_f = last_up ? any_above(pend, door_f) : any_below(pend, door_f);
    clr_oh  = enter_door ? onehot(door_f) : '0;
    pc_n = (pc & ~clr_oh) | (car_q & set_mask);
    pu_n = (pu & ~((last_up || !ahead_f) ? clr_oh : '0)) | (up_q & set_mask);
    pd_n = (pd & ~((!last_up || !ahead_f) ? clr_oh : '0)) | (dn_q & set_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      floor   <= '0;
      dir     <= DIR_IDLE;
      door    <= 1'b0;
      alert   <= 1'b0;
      last_up <= 1'b1;
      tcnt    <= '0;
      dcnt    <= '0;
      pc      <= '0;
      pu      <= '0;
      pd      <= '0;
      car_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir     <= dir_n;
      door    <= door_n;
      alert   <= bus.over_weight && (state != MOVE);
      last_up <= last_up_n;
      tcnt    <= tcnt_n;
      dcnt    <= dcnt_n;
      pc      <= pc_n;
      pu      <= pu_n;
      pd      <= pd_n;
      car_q   <= bus.car_call;
      up_q    <= bus.hall_up & UP_MASK;
      dn_q    <= bus.hall_dn & DN_MASK;
    end
  end

  assign bus.current_floor     = floor;
  assign bus.direction         = dir;
  assign bus.door_state        = door;
  assign bus.over_weight_alert = alert;
  assign bus.pending           = pend;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - scoreboard bench for elevator_scan_ctrl door-stop order, timing and status
module tb_elevator_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic door_prev = 1'b0;

  typedef struct {
    int floor;
    int edge_no;
  } exp_t;
  exp_t sb[$];

  elevator_scan_ctrl_if #(.NUM_FLOORS(8), .FLOOR_W(3)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < base + 1 + k) @(negedge clk);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check_eq("sb_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Every door opening must match the next expected stop: floor and edge number.
  always @(negedge clk) begin
    if (bus.door_state && !door_prev) begin
      if (sb.size() == 0) begin
        check_eq("door_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("stop_floor", 32'(bus.current_floor), 32'(e.floor));
        check_eq("stop_edge", 32'(cyc), 32'(e.edge_no));
      end
    end
    door_prev = bus.door_state;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.car_call = '0; bus.hall_up = '0; bus.hall_dn = '0;
    bus.open_door = 1'b0; bus.close_door = 1'b0; bus.over_weight = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_floor", 32'(bus.current_floor), 32'd0);
    check_eq("rst_dir", 32'(bus.direction), 32'd0);
    check_eq("rst_door", 32'(bus.door_state), 32'd0);
    check_eq("rst_alert", 32'(bus.over_weight_alert), 32'd0);
    check_eq("rst_pending", 32'(bus.pending), 32'd0);

    // Single car call from floor 0 to floor 3
    base = cyc;
    bus.car_call = 8'h08;
    sb.push_back('{3, base + 1 + 2 + 3 * 4});
    goto(0); bus.car_call = '0;
    check_eq("t1_pend_e0", 32'(bus.pending), 32'd0);
    goto(1); check_eq("t1_pend_e1", 32'(bus.pending), 32'h08);
    goto(1); check_eq("t1_dir_e1", 32'(bus.direction), 32'd0);
    goto(2); check_eq("t1_dir_e2", 32'(bus.direction), 32'd1);
    goto(5); check_eq("t1_floor_e5", 32'(bus.current_floor), 32'd0);
    goto(6); check_eq("t1_floor_e6", 32'(bus.current_floor), 32'd1);
    goto(10); check_eq("t1_floor_e10", 32'(bus.current_floor), 32'd2);
    goto(14);
    check_eq("t1_floor_e14", 32'(bus.current_floor), 32'd3);
    check_eq("t1_dir_e14", 32'(bus.direction), 32'd0);
    goto(21); check_eq("t1_door_e21", 32'(bus.door_state), 32'd1);
    goto(22);
    check_eq("t1_door_e22", 32'(bus.door_state), 32'd0);
    check_eq("t1_pend_e22", 32'(bus.pending), 32'd0);

    // Reset back to floor 0, then reset aborts travel towards floor 6
    rst = 1'b1; base = cyc; goto(0); rst = 1'b0;
    check_eq("t6_floor0", 32'(bus.current_floor), 32'd0);
    base = cyc;
    bus.car_call = 8'h40;
    goto(0); bus.car_call = '0;
    goto(3); bus.open_door = 1'b1; bus.close_door = 1'b1; bus.over_weight = 1'b1;
    goto(4);
    bus.open_door = 1'b0; bus.close_door = 1'b0; bus.over_weight = 1'b0;
    check_eq("t6_move_door", 32'(bus.door_state), 32'd0);
    check_eq("t6_move_alert", 32'(bus.over_weight_alert), 32'd0);
    check_eq("t6_move_dir", 32'(bus.direction), 32'd1);
    goto(6); check_eq("t6_floor_e6", 32'(bus.current_floor), 32'd1);
    rst = 1'b1;
    goto(7); rst = 1'b0;
    check_eq("t6_rst_floor", 32'(bus.current_floor), 32'd0);
    check_eq("t6_rst_dir", 32'(bus.direction), 32'd0);
    check_eq("t6_rst_pend", 32'(bus.pending), 32'd0);
    goto(17);
    check_eq("t6_after_dir", 32'(bus.direction), 32'd0);
    check_eq("t6_after_door", 32'(bus.door_state), 32'd0);

    // SCAN order: car 5, hall up 2 (stop), hall down 4 (skip, then served on the way down)
    base = cyc;
    bus.car_call = 8'h20;
    sb.push_back('{2, base + 1 + 10});
    sb.push_back('{5, base + 1 + 31});
    sb.push_back('{4, base + 1 + 44});
    goto(0); bus.car_call = '0;
    goto(2); bus.hall_up = 8'h04; bus.hall_dn = 8'h10;
    goto(3); bus.hall_up = '0; bus.hall_dn = '0;
    goto(5); check_eq("t2_pend", 32'(bus.pending), 32'h34);
    goto(27);
    check_eq("t2_skip_floor", 32'(bus.current_floor), 32'd4);
    check_eq("t2_skip_door", 32'(bus.door_state), 32'd0);
    wait_sb(100);
    goto(44); check_eq("t2_dir_down_stop", 32'(bus.direction), 32'd0);
    goto(52);
    check_eq("t2_door_closed", 32'(bus.door_state), 32'd0);
    check_eq("t2_pend_clear", 32'(bus.pending), 32'd0);

    // Overweight freezes the dwell and holds the door
    base = cyc;
    bus.open_door = 1'b1;
    sb.push_back('{4, base + 1});
    goto(0); bus.open_door = 1'b0; bus.over_weight = 1'b1;
    goto(1); check_eq("t3_alert_on", 32'(bus.over_weight_alert), 32'd1);
    goto(20);
    check_eq("t3_door_held", 32'(bus.door_state), 32'd1);
    check_eq("t3_alert_held", 32'(bus.over_weight_alert), 32'd1);
    bus.over_weight = 1'b0;
    goto(21); check_eq("t3_alert_off", 32'(bus.over_weight_alert), 32'd0);
    goto(27); check_eq("t3_door_e27", 32'(bus.door_state), 32'd1);
    goto(28); check_eq("t3_door_e28", 32'(bus.door_state), 32'd0);

    // Door buttons: periodic open holds, open wins over close, close alone shuts
    base = cyc;
    bus.open_door = 1'b1;
    sb.push_back('{4, base + 1});
    goto(0); bus.open_door = 1'b0;
    for (int k = 5; k <= 20; k += 5) begin
      goto(k - 1); bus.open_door = 1'b1;
      goto(k); bus.open_door = 1'b0;
      if (k == 10) check_eq("t4_hold_e10", 32'(bus.door_state), 32'd1);
    end
    goto(22); check_eq("t4_hold_e22", 32'(bus.door_state), 32'd1);
    goto(24); bus.open_door = 1'b1; bus.close_door = 1'b1;
    goto(25); bus.open_door = 1'b0; bus.close_door = 1'b0;
    check_eq("t4_both", 32'(bus.door_state), 32'd1);
    goto(26); bus.close_door = 1'b1;
    goto(27); bus.close_door = 1'b0;
    check_eq("t4_close", 32'(bus.door_state), 32'd0);

    // Car call at the current floor opens without moving; edge hall bits are ignored
    base = cyc;
    bus.car_call = 8'h10;
    sb.push_back('{4, base + 1 + 2});
    goto(0); bus.car_call = '0;
    goto(1); check_eq("t5_door_e1", 32'(bus.door_state), 32'd0);
    goto(2); check_eq("t5_dir_e2", 32'(bus.direction), 32'd0);
    goto(10);
    check_eq("t5_door_e10", 32'(bus.door_state), 32'd0);
    check_eq("t5_pend", 32'(bus.pending), 32'd0);
    base = cyc;
    bus.hall_up = 8'h80; bus.hall_dn = 8'h01;
    goto(0); bus.hall_up = '0; bus.hall_dn = '0;
    goto(1); check_eq("t5_ignored_pend", 32'(bus.pending), 32'd0);
    goto(4);
    check_eq("t5_ignored_dir", 32'(bus.direction), 32'd0);
    check_eq("t5_ignored_door", 32'(bus.door_state), 32'd0);

    repeat (4) @(negedge clk);
    check_eq("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
